// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative MIPS mul/div unit owning HI/LO, with pipeline stall
// Optional build macro MULDIV_EARLY_OUT_EN: multiply stops once the remaining multiplier is zero.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             Clk_in,
    input  logic             Rst_n_in,
    input  logic             Start_in,
    input  logic [5:0]       Func_in,
    input  logic [WIDTH-1:0] A_in,
    input  logic [WIDTH-1:0] B_in,
    output logic [WIDTH-1:0] Hi_out,
    output logic [WIDTH-1:0] Lo_out,
    output logic             Busy_out,
    output logic             Done_out,
    output logic             Stall_out
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0]   hi, lo;
    logic [CW-1:0]      count;
    logic               is_div, neg_q, neg_r, div_zero, signed_op;
    logic [WIDTH-1:0]   a_raw;
    logic [2*WIDTH-1:0] acc, mcand;
    logic [WIDTH-1:0]   work, rem;

    logic               supported, is_md, is_mt, start_md, start_mt;
    logic               op_signed, a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;

    logic [2*WIDTH-1:0] acc_next, prod;
    logic [WIDTH:0]     shifted, diff;
    logic [WIDTH-1:0]   rem_next, work_next, hi_fin, lo_fin;
    logic               last_iter;

    always_comb begin
        supported = 1'b0;
        is_md     = 1'b0;
        is_mt     = 1'b0;
        case (Func_in)
            F_MFHI, F_MFLO: supported = 1'b1;
            F_MTHI, F_MTLO: begin
                supported = 1'b1;
                is_mt     = 1'b1;
            end
            F_MULT, F_MULTU, F_DIV, F_DIVU: begin
                supported = 1'b1;
                is_md     = 1'b1;
            end
            default: ;
        endcase
    end

    assign Busy_out  = (state == S_CALC);
    assign Done_out  = (state == S_DONE);
    assign Stall_out = Start_in & supported & Busy_out;
    assign Hi_out    = hi;
    assign Lo_out    = lo;

    assign start_md  = Start_in & is_md & ~Busy_out;
    assign start_mt  = Start_in & is_mt & ~Busy_out;

    // Func bit 0 marks the unsigned variants, bit 1 marks divide (or LO for MTxx)
    assign op_signed = ~Func_in[0];
    assign a_neg     = op_signed & A_in[WIDTH-1];
    assign b_neg     = op_signed & B_in[WIDTH-1];
    assign a_mag     = a_neg ? -A_in : A_in;
    assign b_mag     = b_neg ? -B_in : B_in;

    always_comb begin
        acc_next  = work[0] ? acc + mcand : acc;
        shifted   = {rem, work[WIDTH-1]};
        diff      = shifted - {1'b0, mcand[WIDTH-1:0]};
        rem_next  = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
        work_next = is_div ? {work[WIDTH-2:0], ~diff[WIDTH]} : (work >> 1);
        last_iter = (count == CW'(WIDTH - 1));
`ifdef MULDIV_EARLY_OUT_EN
        if (!is_div && work_next == '0)
            last_iter = 1'b1;
`endif
        prod   = neg_q ? -acc_next : acc_next;
        hi_fin = prod[2*WIDTH-1:WIDTH];
        lo_fin = prod[WIDTH-1:0];
        if (is_div) begin
            if (div_zero) begin
                hi_fin = a_raw;
                lo_fin = (signed_op && a_raw[WIDTH-1]) ? {{(WIDTH-1){1'b0}}, 1'b1} : '1;
            end else begin
                hi_fin = neg_r ? -rem_next : rem_next;
                lo_fin = neg_q ? -work_next : work_next;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE, S_DONE: state_next = start_md ? S_CALC : S_IDLE;
            S_CALC:         if (last_iter) state_next = S_DONE;
            default:        state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk_in) begin
        if (!Rst_n_in) begin
            state <= S_IDLE;
            hi    <= '0;
            lo    <= '0;
            count <= '0;
        end else begin
            state <= state_next;
            if (start_md) begin
                is_div    <= Func_in[1];
                signed_op <= op_signed;
                neg_q     <= a_neg ^ b_neg;
                neg_r     <= a_neg;
                div_zero  <= (B_in == '0);
                a_raw     <= A_in;
                count     <= '0;
                acc       <= '0;
                rem       <= '0;
                // Divide shifts the dividend out of work; multiply consumes the multiplier from it
                if (Func_in[1]) begin
                    work  <= a_mag;
                    mcand <= {{WIDTH{1'b0}}, b_mag};
                end else begin
                    work  <= b_mag;
                    mcand <= {{WIDTH{1'b0}}, a_mag};
                end
            end else if (start_mt) begin
                if (Func_in[1])
                    lo <= A_in;
                else
                    hi <= A_in;
            end else if (Busy_out) begin
                count <= count + 1'b1;
                acc   <= acc_next;
                work  <= work_next;
                rem   <= rem_next;
                if (!is_div)
                    mcand <= mcand << 1;
                if (last_iter) begin
                    hi <= hi_fin;
                    lo <= lo_fin;
                end
            end
        end
    end

endmodule
